// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM stream reader.
//   state_t   : controller states (IDLE / RUN / FLUSH)
//   BUF_DEPTH : depth of the return-path buffer
//   BUF_CNT_W : width of an occupancy count for that buffer (0..BUF_DEPTH)
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO used as the return buffer of the BRAM stream reader.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data at the tail this cycle
//   push_data  : word to enqueue
//   pop        : drop the head entry this cycle (caller guarantees count != 0)
//   head_data  : current head entry (meaningful while count != 0)
//   count      : number of stored entries, 0..BUF_DEPTH
// Push and pop in the same cycle are both honoured and leave count unchanged.
module stream_fifo2
    import bram_stream_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output logic [BUF_CNT_W-1:0] count
);

    logic [WIDTH-1:0] entries [BUF_DEPTH];
    // Depth is two, so a single bit per pointer wraps naturally.
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + BUF_CNT_W'(1);
                2'b01:   count <= count - BUF_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = entries[rd_ptr];

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side master for a single-port-read BRAM with a 1-cycle registered read.
// Reads len_i words starting at base_addr_i (address wraps modulo the depth)
// and presents them as a valid/ready stream with full back-pressure. A read
// suppressed by a concurrent BRAM write is retried at the same address.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   start_i       : begin a transfer (sampled only in IDLE)
//   base_addr_i   : first word address
//   len_i         : word count, 0..2**memSize_p
//   busy_o        : high while a transfer is in progress
//   done_o        : one-cycle pulse after the transfer completes
//   bram_read_o   : BRAM read enable
//   bram_raddr_o  : BRAM read address
//   bram_write_i  : BRAM write enable copy; suppresses this cycle's read
//   bram_data_i   : BRAM read data
//   data_o, valid_o, ready_i, last_o : output stream
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int unsigned memSize_p   = 8,
    parameter int unsigned dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [memSize_p-1:0]   base_addr_i,
    input  logic [memSize_p:0]     len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   bram_read_o,
    output logic [memSize_p-1:0]   bram_raddr_o,
    input  logic                   bram_write_i,
    input  logic [dataWidth_p-1:0] bram_data_i,
    output logic [dataWidth_p-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o
);

    localparam int unsigned CNT_W = memSize_p + 1;

    state_t               state;
    state_t               state_next;

    logic [memSize_p-1:0] addr;
    logic [CNT_W-1:0]     len_q;
    logic [CNT_W-1:0]     issued;
    logic [CNT_W-1:0]     returned;
    logic                 inflight;
    logic                 done_q;

    logic                 start_ok;
    logic                 start_empty;
    logic                 pop;
    logic                 accept;
    logic                 last_issue;
    logic                 last_hs;
    logic [BUF_CNT_W-1:0] buf_count;
    logic [BUF_CNT_W-1:0] occupancy;

    assign start_ok    = (state == IDLE) && start_i && (len_i != '0);
    assign start_empty = (state == IDLE) && start_i && (len_i == '0);
    assign pop         = valid_o && ready_i;
    assign accept      = bram_read_o && !bram_write_i;
    assign last_issue  = accept && ((issued + CNT_W'(1)) == len_q);
    assign last_hs     = pop && last_o;

    // Buffer slots committed after this cycle, not counting a read issued now.
    // Issuing only while this is below BUF_DEPTH keeps the FIFO from overflowing.
    assign occupancy = buf_count + BUF_CNT_W'(inflight) - BUF_CNT_W'(pop);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok)   state_next = RUN;
            RUN:     if (last_issue) state_next = FLUSH;
            FLUSH:   if (last_hs)    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_o      = (state != IDLE);
        bram_read_o = (state == RUN) && (issued < len_q) &&
                      (occupancy < BUF_CNT_W'(BUF_DEPTH));
    end

    // Address, counters and return tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr     <= '0;
            len_q    <= '0;
            issued   <= '0;
            returned <= '0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Data for a read accepted this cycle appears on bram_data_i next cycle.
            inflight <= accept;
            done_q   <= start_empty || ((state == FLUSH) && last_hs);
            if (start_ok) begin
                addr     <= base_addr_i;
                len_q    <= len_i;
                issued   <= '0;
                returned <= '0;
            end else begin
                if (accept) begin
                    addr   <= addr + memSize_p'(1);
                    issued <= issued + CNT_W'(1);
                end
                if (pop) begin
                    returned <= returned + CNT_W'(1);
                end
            end
        end
    end

    stream_fifo2 #(
        .WIDTH (dataWidth_p)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (inflight),
        .push_data (bram_data_i),
        .pop       (pop),
        .head_data (data_o),
        .count     (buf_count)
    );

    assign valid_o      = (buf_count != '0);
    assign last_o       = valid_o && (returned == (len_q - CNT_W'(1)));
    assign done_o       = done_q;
    assign bram_raddr_o = addr;

endmodule
